smart_vending_machine_mp: RTL and testbench

Parametrised multi-product vending controller, the next generation of the team's single-purchase vending FSM. Differences from the single-purchase FSM:
- Credit accumulates from multiple coin cycles.
- Each product has a stock counter, with sold-out detection and refill.
- Credit is retained on an insufficient selection, and there is a cancel/refund path and an idle timeout.
- Leftover credit carries across buy_more purchases.
Sits between the coin acceptor front end and the dispense/change actuators.

---
 rtl/smart_vending_machine_mp_if.sv | 41 ++++
 rtl/smart_vending_machine_mp.sv | 195 +++++++++++++++++++
 tb/tb_smart_vending_machine_mp.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/smart_vending_machine_mp_if.sv
// Request/response bundle between the coin/select/refill front end and the
// multi-product vending controller. The controller takes the slave side.
interface smart_vending_machine_mp_if #(
    parameter int DATA_W  = 8,
    parameter int SEL_W   = 2,
    parameter int STOCK_W = 4
);
    logic               coin_valid;
    logic [DATA_W-1:0]  coin_value;
    logic               select_valid;
    logic [SEL_W-1:0]   product_select;
    logic               cancel;
    logic               buy_more;
    logic               refill_valid;
    logic [SEL_W-1:0]   refill_sel;
    logic [STOCK_W-1:0] refill_qty;

    logic               dispense;
    logic [SEL_W-1:0]   dispensed_product;
    logic [DATA_W-1:0]  change;
    logic               change_valid;
    logic               insufficient;
    logic               sold_out;
    logic               coin_reject;
    logic [DATA_W-1:0]  credit;
    logic               busy;

    modport master (
        output coin_valid, coin_value, select_valid, product_select, cancel,
               buy_more, refill_valid, refill_sel, refill_qty,
        input  dispense, dispensed_product, change, change_valid, insufficient,
               sold_out, coin_reject, credit, busy
    );

    modport slave (
        input  coin_valid, coin_value, select_valid, product_select, cancel,
               buy_more, refill_valid, refill_sel, refill_qty,
        output dispense, dispensed_product, change, change_valid, insufficient,
               sold_out, coin_reject, credit, busy
    );
endinterface

// File: rtl/smart_vending_machine_mp.sv
// Multi-product vending controller: accumulates credit, checks stock and
// price, dispenses with change, supports buy_more, cancel/timeout refund
// and per-product stock refill. All outputs are registered.
module smart_vending_machine_mp #(
    parameter int                            DATA_W       = 8,
    parameter int                            NUM_PRODUCTS = 4,
    parameter int                            SEL_W        = 2,
    parameter logic [NUM_PRODUCTS*DATA_W-1:0] PRICE_LIST  = {8'd100, 8'd75, 8'd50, 8'd25},
    parameter int                            STOCK_W      = 4,
    parameter int                            INIT_STOCK   = 5,
    parameter int                            TIMEOUT_CYC  = 255
) (
    input  logic                     clk,
    input  logic                     reset_n,
    smart_vending_machine_mp_if.slave bus
);
    localparam int TMR_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [STOCK_W:0] STOCK_MAX = {1'b0, {STOCK_W{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_CHECK, S_DISPENSE, S_CHANGE, S_REFUND
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_credit;
    logic [SEL_W-1:0]    r_sel;
    logic [TMR_W-1:0]    r_timer;
    logic [STOCK_W-1:0]  r_stock [NUM_PRODUCTS];

    logic                r_dispense;
    logic [SEL_W-1:0]    r_dispensed_product;
    logic [DATA_W-1:0]   r_change;
    logic                r_change_valid;
    logic                r_insufficient;
    logic                r_sold_out;
    logic                r_coin_reject;
    logic                r_busy;

    logic [DATA_W-1:0]   w_price_tbl [NUM_PRODUCTS];
    logic [STOCK_W-1:0]  w_stock_next [NUM_PRODUCTS];
    logic [DATA_W-1:0]   w_price;
    logic [DATA_W-1:0]   w_remain;
    logic [DATA_W:0]     w_coin_sum;
    logic                w_busy_state;
    logic                w_coin_ok;
    logic                w_sel_ok;
    logic                w_timeout_hit;
    logic [STOCK_W-1:0]  w_stock_sel;

    // Per-product price slices and next-stock values (decrement on dispense,
    // saturating refill; both may hit the same product in one cycle).
    generate
        for (genvar gi = 0; gi < NUM_PRODUCTS; gi++) begin : g_prod
            logic            w_dec;
            logic            w_add;
            logic [STOCK_W:0] w_sum;
            assign w_price_tbl[gi] = PRICE_LIST[gi*DATA_W +: DATA_W];
            assign w_dec = (r_state == S_DISPENSE) && (r_sel == SEL_W'(gi));
            assign w_add = bus.refill_valid && (bus.refill_sel == SEL_W'(gi));
            assign w_sum = {1'b0, r_stock[gi]}
                         + (w_add ? {1'b0, bus.refill_qty} : {(STOCK_W+1){1'b0}})
                         - {{STOCK_W{1'b0}}, w_dec};
            assign w_stock_next[gi] = (w_sum > STOCK_MAX) ? {STOCK_W{1'b1}} : w_sum[STOCK_W-1:0];
        end
    endgenerate

    assign w_price       = w_price_tbl[r_sel];
    assign w_remain      = r_credit - w_price;
    assign w_stock_sel   = r_stock[r_sel];
    assign w_coin_sum    = {1'b0, r_credit} + {1'b0, bus.coin_value};
    assign w_busy_state  = (r_state == S_CHECK) || (r_state == S_DISPENSE) ||
                           (r_state == S_CHANGE) || (r_state == S_REFUND);
    // A coin only lands when nothing higher-priority is happening and it fits.
    assign w_coin_ok     = bus.coin_valid && !bus.cancel && !bus.select_valid &&
                           !w_busy_state && !w_coin_sum[DATA_W];
    assign w_sel_ok      = 32'(bus.product_select) < 32'(NUM_PRODUCTS);
    assign w_timeout_hit = (TIMEOUT_CYC != 0) && (r_timer == TMR_W'(TIMEOUT_CYC - 1));

    // Stock counters: reload on reset, otherwise take the combined update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PRODUCTS; i++) r_stock[i] <= STOCK_W'(INIT_STOCK);
        end else begin
            for (int i = 0; i < NUM_PRODUCTS; i++) r_stock[i] <= w_stock_next[i];
        end
    end

    // Main controller FSM with registered pulse outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state             <= S_IDLE;
            r_credit            <= '0;
            r_sel               <= '0;
            r_timer             <= '0;
            r_dispense          <= 1'b0;
            r_dispensed_product <= '0;
            r_change            <= '0;
            r_change_valid      <= 1'b0;
            r_insufficient      <= 1'b0;
            r_sold_out          <= 1'b0;
            r_coin_reject       <= 1'b0;
            r_busy              <= 1'b0;
        end else begin
            r_dispense          <= 1'b0;
            r_dispensed_product <= '0;
            r_change            <= '0;
            r_change_valid      <= 1'b0;
            r_insufficient      <= 1'b0;
            r_sold_out          <= 1'b0;
            r_coin_reject       <= bus.coin_valid && !w_coin_ok;
            r_timer             <= '0;
            case (r_state)
                S_IDLE: begin
                    // cancel with no credit does nothing and still wins priority
                    if (!bus.cancel) begin
                        if (bus.select_valid) begin
                            if (w_sel_ok) begin
                                r_sel   <= bus.product_select;
                                r_state <= S_CHECK;
                                r_busy  <= 1'b1;
                            end
                        end else if (w_coin_ok) begin
                            r_credit <= w_coin_sum[DATA_W-1:0];
                            if (w_coin_sum != '0) r_state <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (bus.cancel || (!bus.select_valid && !w_coin_ok && w_timeout_hit)) begin
                        r_state        <= S_REFUND;
                        r_change       <= r_credit;
                        r_change_valid <= 1'b1;
                        r_busy         <= 1'b1;
                    end else if (bus.select_valid) begin
                        if (w_sel_ok) begin
                            r_sel   <= bus.product_select;
                            r_state <= S_CHECK;
                            r_busy  <= 1'b1;
                        end
                    end else if (w_coin_ok) begin
                        r_credit <= w_coin_sum[DATA_W-1:0];
                    end else if (TIMEOUT_CYC != 0) begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_CHECK: begin
                    if (w_stock_sel == '0) begin
                        r_sold_out <= 1'b1;
                        r_state    <= (r_credit != '0) ? S_COLLECT : S_IDLE;
                        r_busy     <= 1'b0;
                    end else if (r_credit < w_price) begin
                        r_insufficient <= 1'b1;
                        r_state        <= (r_credit != '0) ? S_COLLECT : S_IDLE;
                        r_busy         <= 1'b0;
                    end else begin
                        r_state             <= S_DISPENSE;
                        r_dispense          <= 1'b1;
                        r_dispensed_product <= r_sel;
                    end
                end
                S_DISPENSE: begin
                    r_credit <= w_remain;
                    if (bus.buy_more && (w_remain != '0)) begin
                        r_state <= S_COLLECT;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state        <= S_CHANGE;
                        r_change       <= w_remain;
                        r_change_valid <= 1'b1;
                    end
                end
                S_CHANGE, S_REFUND: begin
                    r_credit <= '0;
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_credit <= '0;
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dispense          = r_dispense;
    assign bus.dispensed_product = r_dispensed_product;
    assign bus.change            = r_change;
    assign bus.change_valid      = r_change_valid;
    assign bus.insufficient      = r_insufficient;
    assign bus.sold_out          = r_sold_out;
    assign bus.coin_reject       = r_coin_reject;
    assign bus.credit            = r_credit;
    assign bus.busy              = r_busy;
endmodule

// File: tb/tb_smart_vending_machine_mp.sv
// Bench for smart_vending_machine_mp: directed scenarios plus random
// transactions, checked against a transaction-level credit/stock model.
module tb_smart_vending_machine_mp;
    localparam int TIMEOUT = 255;
    localparam int MAXC    = 255;
    localparam int MAXS    = 15;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    smart_vending_machine_mp_if #(.DATA_W(8), .SEL_W(2), .STOCK_W(4)) bus ();
    smart_vending_machine_mp dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int n_checks = 0;
    int n_errors = 0;
    int m_credit = 0;
    int m_idle   = 0;
    int m_stock [4];
    int price_tbl [4] = '{25, 50, 75, 100};
    int coin_tbl  [7] = '{5, 10, 20, 25, 50, 100, 200};

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.coin_valid = 0; bus.coin_value = '0; bus.select_valid = 0;
        bus.product_select = '0; bus.cancel = 0; bus.buy_more = 0;
        bus.refill_valid = 0; bus.refill_sel = '0; bus.refill_qty = '0;
    endtask

    task automatic model_reset();
        m_credit = 0; m_idle = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = 5;
    endtask

    function automatic int sat_stock(input int v);
        return (v > MAXS) ? MAXS : v;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_dispense"}, bus.dispense, 0);
        check_eq({tag, "_dprod"}, bus.dispensed_product, 0);
        check_eq({tag, "_change"}, bus.change, 0);
        check_eq({tag, "_change_valid"}, bus.change_valid, 0);
        check_eq({tag, "_insufficient"}, bus.insufficient, 0);
        check_eq({tag, "_sold_out"}, bus.sold_out, 0);
        check_eq({tag, "_coin_reject"}, bus.coin_reject, 0);
        check_eq({tag, "_credit"}, bus.credit, 0);
        check_eq({tag, "_busy"}, bus.busy, 0);
    endtask

    task automatic insert_coin(input int v);
        bit rej;
        rej = (m_credit + v) > MAXC;
        bus.coin_valid = 1; bus.coin_value = 8'(v);
        tick();
        bus.coin_valid = 0;
        check_eq("coin_reject", bus.coin_reject, int'(rej));
        if (!rej) begin
            m_credit += v; m_idle = 0;
        end else if (m_credit > 0) begin
            m_idle++;
        end
        check_eq("coin_credit", bus.credit, m_credit);
        check_eq("coin_busy", bus.busy, 0);
        $display("txn coin %0d reject=%0d credit=%0d", v, rej, m_credit);
    endtask

    // wc: 0 no coin, 1 coin alongside select, 2 coin during the check cycle
    task automatic do_select(input int p, input int bm, input int wc,
                             input int rf, input int rs, input int rq);
        bit exp_so, exp_ins, exp_disp;
        int rem;
        bus.select_valid = 1; bus.product_select = 2'(p); bus.buy_more = bm[0];
        if (wc == 1) begin bus.coin_valid = 1; bus.coin_value = 8'd5; end
        tick();
        bus.select_valid = 0; bus.coin_valid = 0;
        m_idle = 0;
        check_eq("sel_busy", bus.busy, 1);
        if (wc == 1) check_eq("sel_coin_reject", bus.coin_reject, 1);
        if (wc == 2) begin bus.coin_valid = 1; bus.coin_value = 8'd5; end
        tick();
        bus.coin_valid = 0;
        if (wc == 2) check_eq("busy_coin_reject", bus.coin_reject, 1);
        exp_so   = (m_stock[p] == 0);
        exp_ins  = !exp_so && (m_credit < price_tbl[p]);
        exp_disp = !exp_so && !exp_ins;
        check_eq("sold_out", bus.sold_out, int'(exp_so));
        check_eq("insufficient", bus.insufficient, int'(exp_ins));
        check_eq("dispense", bus.dispense, int'(exp_disp));
        check_eq("check_credit", bus.credit, m_credit);
        if (exp_disp) begin
            check_eq("dispensed_product", bus.dispensed_product, p);
            if (rf != 0) begin
                bus.refill_valid = 1; bus.refill_sel = 2'(rs); bus.refill_qty = 4'(rq);
            end
            tick();
            bus.refill_valid = 0;
            rem = m_credit - price_tbl[p];
            m_stock[p]--;
            if (rf != 0) m_stock[rs] = sat_stock(m_stock[rs] + rq);
            check_eq("disp_pulse_end", bus.dispense, 0);
            if (bm != 0 && rem > 0) begin
                check_eq("bm_change_valid", bus.change_valid, 0);
                check_eq("bm_credit", bus.credit, rem);
                check_eq("bm_busy", bus.busy, 0);
                m_credit = rem;
            end else begin
                check_eq("change_valid", bus.change_valid, 1);
                check_eq("change", bus.change, rem);
                tick();
                check_eq("post_change_credit", bus.credit, 0);
                check_eq("post_change_valid", bus.change_valid, 0);
                check_eq("post_change_busy", bus.busy, 0);
                m_credit = 0;
            end
        end else begin
            check_eq("reject_busy", bus.busy, 0);
        end
        $display("txn select p=%0d bm=%0d so=%0d ins=%0d disp=%0d credit=%0d",
                 p, bm, exp_so, exp_ins, exp_disp, m_credit);
    endtask

    task automatic do_cancel();
        bus.cancel = 1;
        tick();
        bus.cancel = 0;
        if (m_credit > 0) begin
            check_eq("refund_valid", bus.change_valid, 1);
            check_eq("refund_amount", bus.change, m_credit);
            check_eq("refund_busy", bus.busy, 1);
            tick();
        end else begin
            check_eq("idle_cancel_valid", bus.change_valid, 0);
        end
        check_eq("cancel_credit", bus.credit, 0);
        check_eq("cancel_busy", bus.busy, 0);
        $display("txn cancel refund=%0d", m_credit);
        m_credit = 0; m_idle = 0;
    endtask

    task automatic do_refill(input int p, input int q);
        bus.refill_valid = 1; bus.refill_sel = 2'(p); bus.refill_qty = 4'(q);
        tick();
        bus.refill_valid = 0;
        m_stock[p] = sat_stock(m_stock[p] + q);
        if (m_credit > 0) m_idle++;
        check_eq("refill_credit", bus.credit, m_credit);
        $display("txn refill p=%0d q=%0d stock=%0d", p, q, m_stock[p]);
    endtask

    task automatic wait_idle(input int n);
        bit fired;
        fired = 0;
        for (int i = 0; i < n && !fired; i++) begin
            tick();
            if (m_credit > 0) begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    check_eq("timeout_valid", bus.change_valid, 1);
                    check_eq("timeout_amount", bus.change, m_credit);
                    tick();
                    check_eq("timeout_credit", bus.credit, 0);
                    m_credit = 0; m_idle = 0; fired = 1;
                end
            end
        end
        if (!fired) begin
            check_eq("idle_change_valid", bus.change_valid, 0);
            check_eq("idle_credit", bus.credit, m_credit);
        end
        $display("txn idle %0d timeout=%0d credit=%0d", n, fired, m_credit);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        model_reset();
        reset_n = 0;
        tick(); tick();
        check_outputs_zero("reset");
        reset_n = 1;
        tick();

        // basic purchase with change
        insert_coin(20); insert_coin(20); insert_coin(20);
        do_select(1, 0, 0, 0, 0, 0);
        // insufficient keeps credit, then top up
        insert_coin(25); insert_coin(5);
        do_select(2, 0, 0, 0, 0, 0);
        insert_coin(50);
        do_select(2, 0, 0, 0, 0, 0);
        // buy_more carries credit
        insert_coin(100);
        do_select(0, 1, 0, 0, 0, 0);
        do_select(1, 0, 0, 0, 0, 0);
        // sell out product 3
        for (int i = 0; i < 6; i++) begin
            insert_coin(100);
            do_select(3, 0, 0, 0, 0, 0);
        end
        do_cancel();
        do_refill(3, 2);
        do_refill(3, 15);
        // refund paths
        insert_coin(20); insert_coin(20);
        do_cancel();
        do_cancel();
        insert_coin(20); insert_coin(20);
        wait_idle(300);
        insert_coin(100); insert_coin(100); insert_coin(50);
        insert_coin(10);
        do_cancel();

        // random transactions
        for (int n = 0; n < 200; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (m_idle >= 200) op = 4;
            case (op)
                0, 1, 2, 3: insert_coin(coin_tbl[$urandom_range(0, 6)]);
                4, 5, 6: do_select($urandom_range(0, 3), $urandom_range(0, 1),
                                   ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0,
                                   ($urandom_range(0, 3) == 0) ? 1 : 0,
                                   $urandom_range(0, 3), $urandom_range(0, 15));
                7: do_cancel();
                8: do_refill($urandom_range(0, 3), $urandom_range(0, 15));
                default: wait_idle($urandom_range(1, 10));
            endcase
        end

        // reset in the middle of a dispense
        do_cancel();
        do_refill(1, 15);
        insert_coin(50);
        bus.select_valid = 1; bus.product_select = 2'd1;
        tick();
        bus.select_valid = 0;
        tick();
        check_eq("pre_reset_dispense", bus.dispense, 1);
        reset_n = 0;
        #1;
        check_outputs_zero("mid_reset");
        @(posedge clk);
        #1;
        reset_n = 1;
        model_reset();
        $display("txn reset mid-dispense");
        for (int i = 0; i < 6; i++) begin
            insert_coin(50);
            do_select(1, 0, 0, 0, 0, 0);
        end
        do_cancel();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
